// File: rtl/t03_tick_monitor.sv
// t03_tick_monitor: receive-side checker for the divided timebase strobe.
// It measures the interval between rising edges of tick_in and reports each one.
// Sticky early/late flags and a lock indicator qualify the timebase.
module t03_tick_monitor #(
  parameter int unsigned CTR_W      = 23,
  parameter int unsigned EXP_PERIOD = 5000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             hwclk,
  input  logic             nrst,
  input  logic             en,
  input  logic             tick_in,
  input  logic             clr_err,
  output logic [CTR_W-1:0] period,
  output logic             period_valid,
  output logic             early,
  output logic             late,
  output logic             lock
);

  localparam int unsigned       GCNT_W   = $clog2(LOCK_N + 1);
  localparam logic [CTR_W-1:0]  LO_CNT   = CTR_W'(EXP_PERIOD - TOL);
  localparam logic [CTR_W-1:0]  HI_CNT   = CTR_W'(EXP_PERIOD + TOL);
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [GCNT_W-1:0] GCNT_MAX = GCNT_W'(LOCK_N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               tick_d_q, tick_d_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [GCNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CTR_W-1:0]   period_q, period_d;
  logic               period_valid_q, period_valid_d;
  logic               early_q, early_d;
  logic               late_q, late_d;
  logic               lock_q, lock_d;

  logic               tick_edge_c;
  logic [CTR_W-1:0]   ctr_inc;
  logic [GCNT_W-1:0]  good_inc;

  assign tick_edge_c = tick_in & ~tick_d_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge hwclk) begin
    if (!nrst) begin
      state_q        <= ST_IDLE;
      tick_d_q       <= 1'b0;
      ctr_q          <= '0;
      good_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;
      lock_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_d_q       <= tick_d_d;
      ctr_q          <= ctr_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      early_q        <= early_d;
      late_q         <= late_d;
      lock_q         <= lock_d;
    end
  end

  // Next-state, interval counting, classification and sticky flags.
  always_comb begin
    state_d        = state_q;
    tick_d_d       = tick_in;
    ctr_d          = ctr_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    // clr_err is applied first so that a same-cycle set below wins.
    early_d        = early_q & ~clr_err;
    late_d         = late_q & ~clr_err;
    lock_d         = lock_q;
    ctr_inc        = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + CTR_W'(1);
    good_inc       = (good_cnt_q == GCNT_MAX) ? good_cnt_q : good_cnt_q + GCNT_W'(1);

    if (!en) begin
      // Leaving for IDLE drops the measurement; period and error flags hold.
      state_d    = ST_IDLE;
      tick_d_d   = 1'b0;
      ctr_d      = '0;
      good_cnt_d = '0;
      lock_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d_d = 1'b0;
          state_d  = ST_ARM;
        end
        ST_ARM: begin
          if (tick_edge_c) begin
            state_d = ST_MEASURE;
            ctr_d   = CTR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (tick_edge_c) begin
            period_d       = ctr_q;
            period_valid_d = 1'b1;
            ctr_d          = CTR_W'(1);
            if (ctr_q < LO_CNT) begin
              early_d    = 1'b1;
              good_cnt_d = '0;
              lock_d     = 1'b0;
            end else if (ctr_q <= HI_CNT) begin
              good_cnt_d = good_inc;
              if (good_inc == GCNT_MAX) begin
                lock_d = 1'b1;
              end
            end else begin
              good_cnt_d = '0;
            end
          end else begin
            ctr_d = ctr_inc;
            // Counter crossing HI_CNT+1 is the timeout; it happens once per interval.
            if (ctr_q == HI_CNT) begin
              late_d     = 1'b1;
              good_cnt_d = '0;
              lock_d     = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign early        = early_q;
  assign late         = late_q;
  assign lock         = lock_q;

endmodule

// File: tb/tb_t03_tick_monitor.sv
// Scoreboard bench for t03_tick_monitor: instance A (CTR_W=8) and instance B (CTR_W=4).
module tb_t03_tick_monitor;

  logic       clk;
  logic       nrst;
  logic       en_a, tick_a, clr_a;
  logic       en_b, tick_b, clr_b;
  logic [7:0] period_a;
  logic [3:0] period_b;
  logic       pv_a, early_a, late_a, lock_a;
  logic       pv_b, early_b, late_b, lock_b;

  int total;
  int bad;
  int unsigned q_a[$];
  int unsigned q_b[$];
  logic pv_a_prev;
  logic pv_b_prev;

  t03_tick_monitor #(.CTR_W(8), .EXP_PERIOD(10), .TOL(2), .LOCK_N(4)) u_dut_a (
    .hwclk(clk), .nrst(nrst), .en(en_a), .tick_in(tick_a), .clr_err(clr_a),
    .period(period_a), .period_valid(pv_a), .early(early_a), .late(late_a), .lock(lock_a)
  );

  t03_tick_monitor #(.CTR_W(4), .EXP_PERIOD(10), .TOL(2), .LOCK_N(4)) u_dut_b (
    .hwclk(clk), .nrst(nrst), .en(en_b), .tick_in(tick_b), .clr_err(clr_b),
    .period(period_b), .period_valid(pv_b), .early(early_b), .late(late_b), .lock(lock_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Single-cycle tick on A; when rep is set, the expected period is queued.
  task automatic tick_a_1(input bit rep, input int unsigned p);
    if (rep) q_a.push_back(p);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
  endtask

  // Scoreboard monitors: pop and compare whenever a period is presented.
  always @(negedge clk) begin
    if (pv_a === 1'b1) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_valid: got period=%0d, required no report", period_a);
      end else begin
        check("a_period", 32'(period_a), q_a.pop_front());
      end
      if (pv_a_prev === 1'b1) check("a_valid_back_to_back", 32'(pv_a_prev), 32'd0);
    end
    pv_a_prev = pv_a;
  end

  always @(negedge clk) begin
    if (pv_b === 1'b1) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_valid: got period=%0d, required no report", period_b);
      end else begin
        check("b_period", 32'(period_b), q_b.pop_front());
      end
    end
    pv_b_prev = pv_b;
  end

  initial begin
    total = 0; bad = 0;
    pv_a_prev = 1'b0; pv_b_prev = 1'b0;
    nrst = 1'b0;
    en_a = 1'b0; tick_a = 1'b0; clr_a = 1'b0;
    en_b = 1'b0; tick_b = 1'b0; clr_b = 1'b0;

    // Reset / arm
    idle(3);
    check("rst_period", 32'(period_a), 32'd0);
    check("rst_valid",  32'(pv_a),     32'd0);
    check("rst_early",  32'(early_a),  32'd0);
    check("rst_late",   32'(late_a),   32'd0);
    check("rst_lock",   32'(lock_a),   32'd0);
    nrst = 1'b1; en_a = 1'b1;
    cyc();
    tick_a_1(1'b0, 0);
    for (int k = 2; k <= 5; k++) begin
      idle(9);
      tick_a_1(1'b1, 10);
      if (k == 4) check("lock_after_4th", 32'(lock_a), 32'd0);
    end
    check("lock_after_5th", 32'(lock_a), 32'd1);
    check("arm_early", 32'(early_a), 32'd0);
    check("arm_late",  32'(late_a),  32'd0);

    // Early interval
    idle(5);
    tick_a_1(1'b1, 6);
    check("early_set",  32'(early_a), 32'd1);
    check("early_lock", 32'(lock_a),  32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(9);
      tick_a_1(1'b1, 10);
      if (k == 3) check("relock_after_3", 32'(lock_a), 32'd0);
    end
    check("relock", 32'(lock_a), 32'd1);
    check("early_sticky", 32'(early_a), 32'd1);

    // Late / timeout
    idle(11);
    check("late_before_13", 32'(late_a), 32'd0);
    check("lock_before_13", 32'(lock_a), 32'd1);
    idle(1);
    check("late_at_13", 32'(late_a), 32'd1);
    check("lock_at_13", 32'(lock_a), 32'd0);
    idle(7);
    tick_a_1(1'b1, 20);
    check("late_after_20", 32'(lock_a), 32'd0);

    // clr_err, then collision with the timeout
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
    check("clr_early", 32'(early_a), 32'd0);
    check("clr_late",  32'(late_a),  32'd0);
    idle(10);
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
    check("collision_late", 32'(late_a), 32'd1);
    clr_a = 1'b1; cyc(); clr_a = 1'b0;
    check("clr_after_collision", 32'(late_a), 32'd0);

    // Re-lock with early set, then disable mid-interval
    idle(2);
    tick_a_1(1'b1, 16);
    idle(5);
    tick_a_1(1'b1, 6);
    for (int k = 1; k <= 4; k++) begin
      idle(9);
      tick_a_1(1'b1, 10);
    end
    check("pre_dis_lock", 32'(lock_a), 32'd1);
    idle(4);
    en_a = 1'b0;
    cyc();
    check("dis_lock",   32'(lock_a),   32'd0);
    check("dis_period", 32'(period_a), 32'd10);
    check("dis_early",  32'(early_a),  32'd1);
    check("dis_late",   32'(late_a),   32'd0);
    check("dis_valid",  32'(pv_a),     32'd0);
    en_a = 1'b1;
    cyc();
    idle(2);
    tick_a_1(1'b0, 0);
    idle(9);
    tick_a_1(1'b1, 10);
    check("reen_lock", 32'(lock_a), 32'd0);

    // Reset mid-interval
    idle(4);
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    check("mrst_period", 32'(period_a), 32'd0);
    check("mrst_valid",  32'(pv_a),     32'd0);
    check("mrst_early",  32'(early_a),  32'd0);
    check("mrst_late",   32'(late_a),   32'd0);
    check("mrst_lock",   32'(lock_a),   32'd0);
    cyc();
    tick_a_1(1'b0, 0);
    idle(9);
    tick_a_1(1'b1, 10);

    // Wide pulse and saturation on the 4-bit instance
    en_b = 1'b1;
    cyc();
    tick_b = 1'b1; cyc(); tick_b = 1'b0;
    idle(9);
    q_b.push_back(10);
    tick_b = 1'b1;
    idle(5);
    tick_b = 1'b0;
    idle(40);
    check("b_late", 32'(late_b), 32'd1);
    check("b_early", 32'(early_b), 32'd0);
    q_b.push_back(15);
    tick_b = 1'b1; cyc(); tick_b = 1'b0;

    idle(3);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
